// File: rtl/csi_i2c_pkg.sv
// Shared types and constants for the camera-sensor I2C bring-up path.
package csi_i2c_pkg;

  localparam int REG_ADDR_W = 16;
  localparam int REG_DATA_W = 8;
  localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;

  localparam logic [REG_ADDR_W-1:0] END_MARKER   = 16'hFFFF;
  localparam logic [REG_ADDR_W-1:0] DELAY_MARKER = 16'hFFFE;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_FINISH,
    ST_FAIL
  } seq_state_t;

endpackage

// File: rtl/cam_init_rom.sv
// Sensor init list: {reg_addr, data} entries, one clock read latency, END-terminated.
module cam_init_rom
  import csi_i2c_pkg::*;
#(
  parameter int NUM_ENTRIES = 256,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic               clk_ext,
  input  logic [IDX_W-1:0]   rom_addr,
  output logic [ENTRY_W-1:0] rom_data
);

  always_ff @(posedge clk_ext) begin
    case (rom_addr)
      IDX_W'(0): rom_data <= {16'h0103, 8'h01};
      // 5 ms settle after software reset before touching the sensor again
      IDX_W'(1): rom_data <= {DELAY_MARKER, 8'h05};
      IDX_W'(2): rom_data <= {16'h0100, 8'h00};
      IDX_W'(3): rom_data <= {16'h0114, 8'h01};
      IDX_W'(4): rom_data <= {16'h0128, 8'h00};
      IDX_W'(5): rom_data <= {16'h012A, 8'h18};
      IDX_W'(6): rom_data <= {16'h012B, 8'h00};
      IDX_W'(7): rom_data <= {16'h0100, 8'h01};
      default:   rom_data <= {END_MARKER, 8'h00};
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table and feeds register writes to the I2C master,
// with strobe-timed gaps/delays and timeout-based retry on NACK.
module i2c_init_sequencer
  import csi_i2c_pkg::*;
#(
  parameter int         NUM_ENTRIES        = 256,
  parameter logic [6:0] SLAVE_ADDR         = DEFAULT_SLAVE_ADDR,
  parameter int         TIMEOUT_STROBES    = 200,
  parameter int         GAP_STROBES        = 4,
  parameter int         DELAY_UNIT_STROBES = 400,
  parameter int         MAX_RETRY          = 3,
  localparam int        IDX_W              = $clog2(NUM_ENTRIES)
) (
  input  logic             clk_ext,
  input  logic             reset,
  input  logic             strobe,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [23:0]      rom_data,
  output logic             i2c_enable,
  output logic             i2c_read_write,
  output logic [6:0]       i2c_slave_address,
  output logic [15:0]      i2c_register_address,
  output logic [7:0]       i2c_data_in,
  input  logic             i2c_register_done,
  output logic             busy,
  output logic             seq_done,
  output logic             seq_error,
  output logic [IDX_W-1:0] err_index
);

  localparam int DELAY_MAX = 255 * DELAY_UNIT_STROBES;
  localparam int WAIT_MAX  = (TIMEOUT_STROBES > GAP_STROBES) ? TIMEOUT_STROBES : GAP_STROBES;
  localparam int CNT_MAX   = (DELAY_MAX > WAIT_MAX) ? DELAY_MAX : WAIT_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   TIMEOUT_C   = CNT_W'(TIMEOUT_STROBES);
  localparam logic [CNT_W-1:0]   GAP_C       = CNT_W'(GAP_STROBES);
  localparam logic [CNT_W-1:0]   UNIT_C      = CNT_W'(DELAY_UNIT_STROBES);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_pend_q, retry_pend_d;
  logic [15:0]        reg_addr_d;
  logic [7:0]         reg_data_d;
  logic [IDX_W-1:0]   err_idx_d;
  logic               done_d, error_d, busy_d, advance;

  logic [15:0] entry_addr;
  logic [7:0]  entry_data;

  assign entry_addr     = rom_data[23:8];
  assign entry_data     = rom_data[7:0];
  assign i2c_read_write = 1'b0;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
    reg_addr_d   = i2c_register_address;
    reg_data_d   = i2c_data_in;
    err_idx_d    = err_index;
    done_d       = seq_done;
    error_d      = seq_error;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH, ST_FAIL: begin
        if (start) begin
          state_d = ST_FETCH;
          index_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (entry_addr == END_MARKER) begin
          state_d = ST_FINISH;
        end else if (entry_addr == DELAY_MARKER) begin
          if (entry_data == 8'd0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = CNT_W'(entry_data) * UNIT_C;
            state_d = ST_DELAY;
          end
        end else begin
          reg_addr_d   = entry_addr;
          reg_data_d   = entry_data;
          retry_d      = '0;
          retry_pend_d = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = TIMEOUT_C;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // completion takes priority over a timeout landing on the same clock
        if (i2c_register_done) begin
          retry_pend_d = 1'b0;
          cnt_d        = GAP_C;
          state_d      = ST_GAP;
        end else if (strobe) begin
          if (cnt_q == CNT_ONE) begin
            if (retry_q < MAX_RETRY_C) begin
              retry_d      = retry_q + RETRY_W'(1);
              retry_pend_d = 1'b1;
              cnt_d        = GAP_C;
              state_d      = ST_GAP;
            end else begin
              err_idx_d = index_q;
              state_d   = ST_FAIL;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (strobe) begin
          if (cnt_q == CNT_ONE) begin
            if (retry_pend_q) state_d = ST_ISSUE;
            else              advance = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_DELAY: begin
        if (strobe) begin
          if (cnt_q == CNT_ONE) advance = 1'b1;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // running off the end of a table without END marker is a normal finish
    if (advance) begin
      if (index_q == LAST_IDX) begin
        state_d = ST_FINISH;
      end else begin
        index_d = index_q + IDX_W'(1);
        state_d = ST_FETCH;
      end
    end

    if (state_d == ST_FINISH) done_d  = 1'b1;
    if (state_d == ST_FAIL)   error_d = 1'b1;
    busy_d = !(state_d inside {ST_IDLE, ST_FINISH, ST_FAIL});
  end

  always_ff @(posedge clk_ext) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      index_q              <= '0;
      cnt_q                <= '0;
      retry_q              <= '0;
      retry_pend_q         <= 1'b0;
      rom_addr             <= '0;
      i2c_enable           <= 1'b0;
      i2c_slave_address    <= SLAVE_ADDR;
      i2c_register_address <= '0;
      i2c_data_in          <= '0;
      busy                 <= 1'b0;
      seq_done             <= 1'b0;
      seq_error            <= 1'b0;
      err_index            <= '0;
    end else begin
      state_q              <= state_d;
      index_q              <= index_d;
      cnt_q                <= cnt_d;
      retry_q              <= retry_d;
      retry_pend_q         <= retry_pend_d;
      rom_addr             <= index_d;
      i2c_enable           <= (state_d == ST_ISSUE);
      i2c_slave_address    <= SLAVE_ADDR;
      i2c_register_address <= reg_addr_d;
      i2c_data_in          <= reg_data_d;
      busy                 <= busy_d;
      seq_done             <= done_d;
      seq_error            <= error_d;
      err_index            <= err_idx_d;
    end
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Walks a table of camera-sensor register writes and feeds them one at a time to the existing I2C master.
- Drives the master's enable, address and data inputs, waits for `register_done` and inserts timed delays.
- Detects NACK-aborted transactions by timeout, then retries or fails.
- Sits between the top-level config-start logic and the I2C master in the CSI receiver's sensor-bring-up path.

Parameters:
- NUM_ENTRIES, 256, depth of the init table; index width is clog2(NUM_ENTRIES).
- SLAVE_ADDR, 7'h10, 7-bit sensor I2C address, constant for every transaction.
- TIMEOUT_STROBES, 200, strobes allowed in WAIT_DONE before a transaction is declared failed.
- GAP_STROBES, 4, strobes idled after each completion before the next issue; minimum 2.
- DELAY_UNIT_STROBES, 400, strobes per delay unit (1 ms at the 400 kHz strobe rate).
- MAX_RETRY, 3, re-issues of one entry before FAIL.

Ports:
- clk_ext  in  1  system clock, shared with the I2C master
- reset  in  1  synchronous, active-high
- strobe  in  1  I2C bit-phase tick, the same signal the master uses
- start  in  1  one-cycle pulse that begins the sequence
- rom_addr  out  clog2(NUM_ENTRIES)  table index
- rom_data  in  24  entry {reg_addr[15:0], data[7:0]}, valid one clock after rom_addr
- i2c_enable  out  1  one-cycle request to the master
- i2c_read_write  out  1  tied 0 (write only)
- i2c_slave_address  out  7  SLAVE_ADDR
- i2c_register_address  out  16  latched reg_addr
- i2c_data_in  out  8  latched data
- i2c_register_done  in  1  master completion flag; level, cleared by the master on accept
- busy  out  1  sequence in progress
- seq_done  out  1  sticky success flag
- seq_error  out  1  sticky failure flag
- err_index  out  clog2(NUM_ENTRIES)  index of the failing entry

Behaviour:
- All outputs are registered. Reset values: every output 0; i2c_slave_address = SLAVE_ADDR; state IDLE; index 0; retry count 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, FINISH, FAIL.
- IDLE: on start, clear seq_done, seq_error and index, set busy, go to FETCH.
  - start is ignored in every state except IDLE, FINISH and FAIL.
- FETCH: drive rom_addr = index, go to DECODE. Table read latency is 1 clock.
- DECODE: classify rom_data.
  - reg_addr == 16'hFFFF: END marker, go to FINISH.
  - reg_addr == 16'hFFFE: DELAY marker. Load data × DELAY_UNIT_STROBES into the delay counter and go to DELAY; data = 0 means no delay, go straight to index+1.
  - Otherwise: latch reg_addr and data onto the i2c outputs, retry count 0, go to ISSUE.
- ISSUE: i2c_enable is high for exactly one clock, on the clock the state is ISSUE. Reset the timeout counter and go to WAIT_DONE.
- WAIT_DONE: count strobes.
  - i2c_register_done == 1: go to GAP.
  - Count reaches TIMEOUT_STROBES: if retry count < MAX_RETRY, increment it and go to GAP then ISSUE; else err_index = index, go to FAIL.
  - Done and timeout on the same clock: done wins.
- GAP: wait GAP_STROBES strobes. This guarantees the master has returned to IDLE before the next enable and prevents a stale done from being read as completion. Then go to ISSUE (retry) or to index+1.
- DELAY: decrement on each strobe; at 0 go to index+1.
- index+1:
  - If index == NUM_ENTRIES-1, go to FINISH (the table has no END marker; this is not an error).
  - Else increment index and go to FETCH.
- FINISH: busy = 0, seq_done = 1. start restarts from index 0.
- FAIL: busy = 0, seq_error = 1, err_index held. start restarts from index 0.
- Counters are wide enough for 255 × DELAY_UNIT_STROBES and for TIMEOUT_STROBES; no wrap is permitted.
- Reset mid-transaction: the sequencer returns to IDLE immediately. The master must share the same reset.

Decomposition:
- Package csi_i2c_pkg holds:
  - sequencer state enum;
  - END_MARKER 16'hFFFF and DELAY_MARKER 16'hFFFE;
  - entry-field widths;
  - default SLAVE_ADDR.
- One sub-module: cam_init_rom, a synchronous 1-clock-latency table indexed by rom_addr that holds the sensor init list and ends with END_MARKER.

Test Plan:
- Table {0x0100/0x00, END}, model master asserts done 50 strobes after enable -> exactly one i2c_enable with register_address 0x0100 and data 0x00; seq_done = 1; busy falls.
- Entry {0xFFFE, 0x05} between two writes -> second i2c_enable occurs ≥ 2000 strobes after the first completion plus GAP.
- Master never asserts done on entry 2 -> 4 enables for that entry (1 + MAX_RETRY), then seq_error = 1, err_index = 2, no further enables.
- Master NACKs the first attempt only -> one retry, sequence completes, seq_done = 1, seq_error = 0.
- Done held high from the previous transaction while the master is slow to return to IDLE -> no enable issued during GAP; no false completion.
- start pulse while busy is ignored; reset asserted mid-WAIT_DONE -> all outputs reach reset values on the next clock and a new start begins at index 0.
